// File: rtl/osd_arb.sv
// osd_arb: shares the OSD byte-command port between a buffered host stream and an internal message source.
// Define OSD_AUTOHIDE_EN to add a frame-counted automatic "hide OSD" command.

module osd_arb #(
  parameter int unsigned FIFO_AW     = 4,
  parameter logic [7:0]  QUIET       = 8'd32,
  parameter logic [11:0] HIDE_FRAMES = 12'd300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_strobe,
  input  logic       host_start,
  input  logic [7:0] host_data,
  input  logic       int_valid,
  input  logic [7:0] int_data,
  input  logic       int_last,
  output logic       int_ready,
  input  logic       vs,
  output logic       osd_strobe,
  output logic       osd_start,
  output logic [7:0] osd_data,
  output logic       osd_visible,
  output logic       host_ovf
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOST,
`ifdef OSD_AUTOHIDE_EN
    S_HIDE,
`endif
    S_INT
  } state_t;

  state_t state;

  // Host byte FIFO: entries are {start, data}.
  logic [8:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               fifo_empty, fifo_full, fifo_wr, fifo_pop;
  logic [8:0]         fifo_head;

  assign fifo_empty = (count == '0);
  assign fifo_full  = count[FIFO_AW];
  assign fifo_wr    = host_strobe && !fifo_full;
  assign fifo_pop   = (state == S_HOST) && !fifo_empty;
  assign fifo_head  = mem[rd_ptr];

  // NOTE: storage array carries no reset; the pointers and count alone define its contents.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= {host_start, host_data};
  end

  // NOTE: sequential state uses non-blocking assignment so every block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      host_ovf <= 1'b0;
    end else begin
      if (fifo_wr)  wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({fifo_wr, fifo_pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
      if (host_strobe && fifo_full) host_ovf <= 1'b1;
    end
  end

  // Host silence counter; a saturated value marks the host message as finished.
  logic [7:0] quiet;

  always_ff @(posedge clk) begin
    if (reset)               quiet <= '0;
    else if (host_strobe)    quiet <= '0;
    else if (quiet != QUIET) quiet <= quiet + 8'd1;
  end

`ifdef OSD_AUTOHIDE_EN
  logic        vs_d;
  logic [11:0] frame_cnt;
  logic        hide_pending;
  logic        frame_tick;

  assign frame_tick = vs_d && !vs && osd_visible && (state != S_HOST);

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_d         <= 1'b0;
      frame_cnt    <= '0;
      hide_pending <= 1'b0;
    end else begin
      vs_d <= vs;
      if (host_strobe || !osd_visible)            frame_cnt <= '0;
      else if (frame_tick && frame_cnt != 12'hFFF) frame_cnt <= frame_cnt + 12'd1;
      // Arm only on the tick that reaches the threshold so a served hide is not re-armed.
      if (host_strobe || state == S_HIDE)
        hide_pending <= 1'b0;
      else if (frame_tick && (frame_cnt + 12'd1 == HIDE_FRAMES))
        hide_pending <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{vs, HIDE_FRAMES};
`endif

  logic int_first;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      osd_strobe <= 1'b0;
      osd_start  <= 1'b0;
      osd_data   <= '0;
      int_ready  <= 1'b0;
      int_first  <= 1'b0;
    end else begin
      osd_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          // A strobe in this very cycle already counts as a host request.
          if (!fifo_empty || host_strobe) begin
            state <= S_HOST;
`ifdef OSD_AUTOHIDE_EN
          end else if (hide_pending) begin
            state      <= S_HIDE;
            osd_strobe <= 1'b1;
            osd_start  <= 1'b1;
            osd_data   <= 8'h01;
`endif
          end else if (int_valid) begin
            state     <= S_INT;
            int_ready <= 1'b1;
            int_first <= 1'b1;
          end
        end
        S_HOST: begin
          if (fifo_pop) begin
            osd_strobe              <= 1'b1;
            {osd_start, osd_data}   <= fifo_head;
          end else if (quiet == QUIET) begin
            state <= S_IDLE;
          end
        end
        S_INT: begin
          if (int_valid && int_ready) begin
            osd_strobe <= 1'b1;
            osd_start  <= int_first;
            osd_data   <= int_data;
            int_first  <= 1'b0;
            if (int_last) begin
              int_ready <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end
`ifdef OSD_AUTOHIDE_EN
        S_HIDE: begin
          osd_strobe <= 1'b1;
          osd_start  <= 1'b0;
          osd_data   <= 8'h00;
          state      <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Visibility follows the emitted stream: command 0x01 then a data byte whose bit 0 is the enable.
  logic [7:0] last_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cmd    <= '0;
      osd_visible <= 1'b0;
    end else if (osd_strobe) begin
      if (osd_start)              last_cmd    <= osd_data;
      else if (last_cmd == 8'h01) osd_visible <= osd_data[0];
    end
  end

endmodule
